// File: rtl/pdm_cic_decoder.sv
// pdm_cic_decoder: 3rd-order CIC decimator, 1-bit PDM in, saturated signed PCM out (latency t+3).
// Define PDM_CIC_INPUT_SYNC_EN to add 2-flop synchronizers on pdm_in/pdm_en (latency t+5).
module pdm_cic_decoder #(
    parameter int WIDTH      = 16,
    parameter int DECIMATION = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pdm_in,
    input  logic             pdm_en,
    output logic [WIDTH-1:0] pcm_out,
    output logic             pcm_valid
);
    localparam int R_LOG2 = $clog2(DECIMATION);
    localparam int ACC_W  = 3 * R_LOG2 + 1;
    localparam int SHIFT  = 3 * R_LOG2 - WIDTH;
    localparam logic [ACC_W-1:0] MID  = ACC_W'(1) << (3 * R_LOG2 - 1);
    localparam logic [ACC_W-1:0] MAXV = MID - ACC_W'(1);

    logic bit_in;
    logic bit_en;

`ifdef PDM_CIC_INPUT_SYNC_EN
    logic [1:0] in_sync;
    logic [1:0] en_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_sync <= '0;
            en_sync <= '0;
        end else begin
            in_sync <= {in_sync[0], pdm_in};
            en_sync <= {en_sync[0], pdm_en};
        end
    end

    assign bit_in = in_sync[1];
    assign bit_en = en_sync[1];
`else
    assign bit_in = pdm_in;
    assign bit_en = pdm_en;
`endif

    logic [ACC_W-1:0]  i1, i2, i3;
    logic [ACC_W-1:0]  i3_next;
    logic [R_LOG2-1:0] cnt;
    logic              frame_end;

    logic [ACC_W-1:0]  d1, d2, d3;
    logic [ACC_W-1:0]  c1, c2, c3;
    logic              v1, v2;
    logic [1:0]        prime;

    logic signed [ACC_W-1:0] s;
    logic signed [ACC_W-1:0] s_sat;
    logic [WIDTH-1:0]        pcm_next;

    assign i3_next   = i3 + i2;
    assign frame_end = bit_en && (cnt == {R_LOG2{1'b1}});

    // Third comb stage is folded into the output register to meet t+3.
    assign c3       = c2 - d3;
    assign s        = $signed(c3 - MID);
    assign s_sat    = (s > $signed(MAXV)) ? $signed(MAXV) : s;
    assign pcm_next = WIDTH'(s_sat >>> SHIFT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i1        <= '0;
            i2        <= '0;
            i3        <= '0;
            cnt       <= '0;
            d1        <= '0;
            d2        <= '0;
            d3        <= '0;
            c1        <= '0;
            c2        <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            prime     <= '0;
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
        end else begin
            // Integrators wrap modulo 2^ACC_W by design; the combs undo the wrap.
            if (bit_en) begin
                i1  <= i1 + ACC_W'(bit_in);
                i2  <= i2 + i1;
                i3  <= i3_next;
                cnt <= cnt + R_LOG2'(1);
            end

            v1 <= frame_end;
            v2 <= v1;

            if (frame_end) begin
                c1 <= i3_next - d1;
                d1 <= i3_next;
            end

            if (v1) begin
                c2 <= c1 - d2;
                d2 <= c1;
            end

            pcm_valid <= 1'b0;
            if (v2) begin
                d3      <= c2;
                pcm_out <= pcm_next;
                // First two outputs carry start-up transients and are not flagged.
                if (prime == 2'd2)
                    pcm_valid <= 1'b1;
                else
                    prime <= prime + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_pdm_cic_decoder.sv
// Directed bench for pdm_cic_decoder: constant, alternating, gated-enable, reset and loopback streams.
module tb_pdm_cic_decoder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        pdm_in = 1'b0;
    logic        pdm_en = 1'b0;
    logic [15:0] pcm_out;
    logic        pcm_valid;

    int checks = 0;
    int errors = 0;

    int          st_time[$];
    logic [15:0] st_val[$];
    logic [15:0] out_hist[$];
    logic        vld_hist[$];
    logic [15:0] dac_acc;

    pdm_cic_decoder #(.WIDTH(16), .DECIMATION(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pdm_in    (pdm_in),
        .pdm_en    (pdm_en),
        .pcm_out   (pcm_out),
        .pcm_valid (pcm_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int st_t(input int i);
        return (st_time.size() > i) ? st_time[i] : -1;
    endfunction

    function automatic logic [15:0] st_v(input int i);
        return (st_val.size() > i) ? st_val[i] : 16'hDEAD;
    endfunction

    // pattern 0: zeros, 1: ones, 2: 1010..., 3: first-order PDM modulator of PCM 0x4000
    function automatic logic next_bit(input int pat, input int nb);
        logic [16:0] sum;
        case (pat)
            0: return 1'b0;
            1: return 1'b1;
            2: return (nb % 2) == 0;
            default: begin
                sum     = {1'b0, dac_acc} + 17'h0C000;
                dac_acc = sum[15:0];
                return sum[16];
            end
        endcase
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        pdm_en  = 1'b0;
        pdm_in  = 1'b0;
        @(posedge clk);
        #1;
        check("reset_out", pcm_out, 0);
        check("reset_vld", pcm_valid, 0);
    endtask

    // Cycle 0 is the reset-release cycle; its bit is accepted at the edge closing it.
    task automatic run_stream(input int pat, input int en_div, input int ncyc, input int rst_at);
        int nb = 0;
        int rel = 0;
        st_time.delete();
        st_val.delete();
        out_hist.delete();
        vld_hist.delete();
        dac_acc = '0;
        for (int c = 0; c < ncyc; c++) begin
            out_hist.push_back(pcm_out);
            vld_hist.push_back(pcm_valid);
            if (pcm_valid) begin
                st_time.push_back(c);
                st_val.push_back(pcm_out);
            end
            if (c == rst_at) begin
                reset_n = 1'b0;
                pdm_en  = 1'b0;
                #1;
                check("rst_async_out", pcm_out, 0);
                check("rst_async_vld", pcm_valid, 0);
            end else begin
                if (reset_n == 1'b0) begin
                    reset_n = 1'b1;
                    rel     = c;
                    nb      = 0;
                    dac_acc = '0;
                end
                pdm_en = ((c - rel) % en_div) == 0;
                if (pdm_en) begin
                    pdm_in = next_bit(pat, nb);
                    nb++;
                end
            end
            @(posedge clk);
            #1;
        end
        pdm_en = 1'b0;
    endtask

    initial begin
        int d;
        #2;

        // All ones: priming outputs C(64,3) and C(128,3)-based, then clamp.
        do_reset();
        run_stream(1, 1, 400, -1);
        check("ones_pre_out", out_hist[65], 16'h0000);
        check("ones_prime1_out", out_hist[66], 16'hA8B0);
        check("ones_prime1_vld", vld_hist[66], 0);
        check("ones_prime2_out", out_hist[130], 16'h5350);
        check("ones_prime2_vld", vld_hist[130], 0);
        check("ones_first_strobe", st_t(0), 194);
        check("ones_strobe2", st_t(1), 258);
        check("ones_strobe3", st_t(2), 322);
        check("ones_count", st_time.size(), 4);
        check("ones_width", vld_hist[195], 0);
        for (int i = 0; i < 3; i++) check("ones_val", st_v(i), 16'h7FFF);

        // All zeros
        do_reset();
        run_stream(0, 1, 300, -1);
        check("zeros_first_strobe", st_t(0), 194);
        check("zeros_count", st_time.size(), 2);
        for (int i = 0; i < 2; i++) check("zeros_val", st_v(i), 16'h8000);

        // Alternating 1,0
        do_reset();
        run_stream(2, 1, 330, -1);
        check("alt_first_strobe", st_t(0), 194);
        check("alt_spacing1", st_t(1) - st_t(0), 64);
        check("alt_spacing2", st_t(2) - st_t(1), 64);
        check("alt_width", vld_hist[259], 0);
        for (int i = 0; i < 3; i++) check("alt_val", st_v(i), 16'h0000);

        // All ones, pdm_en every other cycle
        do_reset();
        run_stream(1, 2, 650, -1);
        check("gap_prime1_out", out_hist[129], 16'hA8B0);
        check("gap_first_strobe", st_t(0), 385);
        check("gap_spacing1", st_t(1) - st_t(0), 128);
        check("gap_spacing2", st_t(2) - st_t(1), 128);
        check("gap_count", st_time.size(), 3);
        for (int i = 0; i < 3; i++) check("gap_val", st_v(i), 16'h7FFF);

        // Reset pulse at bit 37 of frame 4
        do_reset();
        run_stream(1, 1, 500, 293);
        check("rstmid_before_out", out_hist[292], 16'h7FFF);
        check("rstmid_after_out", out_hist[294], 16'h0000);
        check("rstmid_strobe2", st_t(1), 258);
        check("rstmid_next_strobe", st_t(2), 294 + 194);
        check("rstmid_count", st_time.size(), 3);

        // Reset pulse one cycle after the frame-3 capture (comb in flight)
        do_reset();
        run_stream(1, 1, 460, 256);
        check("rstcomb_strobe1", st_t(0), 194);
        check("rstcomb_next_strobe", st_t(1), 257 + 194);
        check("rstcomb_count", st_time.size(), 2);

        // Loopback of a first-order modulator driven with PCM 0x4000
        do_reset();
        run_stream(3, 1, 646, -1);
        check("dac_count", st_time.size(), 8);
        for (int i = 5; i < 8; i++) begin
            d = int'($signed(st_v(i))) - 32'sh4000;
            check("dac_tol", (d >= -512 && d <= 512), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pdm_cic_decoder.md
# pdm_cic_decoder

- Receive-side counterpart to `pdm_dac`.
- Decimates a 1-bit PDM stream into signed PCM samples with a 3rd-order CIC filter (integrate, decimate, comb) and saturating scaling.
- Sits between a PDM source and PCM consumers in the `clk_2x` domain:
  - PDM source: microphone PMOD pin, or `pdm_dac` output in loopback tests.
  - PCM consumers: audio capture logic, test checkers.
- Emits one `pcm_valid` strobe per `DECIMATION` accepted PDM bits.

## Interface

Parameters:
- `WIDTH`, 16: PCM output width, signed two's complement; must satisfy `WIDTH <= 3*log2(DECIMATION)`.
- `DECIMATION`, 64: PDM bits per PCM sample; power of two, ≥ 8.

Derived:
- `R_LOG2 = log2(DECIMATION)`.
- `ACC_W = 3*R_LOG2 + 1` (19 at defaults).

Ports:
- `clk`  in  1: system clock (`clk_2x` domain).
- `reset_n`  in  1: asynchronous, active-low reset.
- `pdm_in`  in  1: PDM bit; 1 = +full scale, 0 = −full scale.
- `pdm_en`  in  1: sample strobe; `pdm_in` is accepted on cycles where `pdm_en` = 1.
- `pcm_out`  out  `WIDTH`: decimated signed sample; holds between strobes.
- `pcm_valid`  out  1: single-cycle strobe, new `pcm_out` present.

## Operation

- Integrators: three `ACC_W`-bit accumulators, I1 += `pdm_in` (0/1), I2 += I1, I3 += I2.
  - All update only on accepted bits.
  - Modulo-2^ACC_W wrap is intentional and must not be saturated.
- Decimation counter: `R_LOG2` bits, increments per accepted bit.
  - On the accepted bit that wraps it to 0 (the `DECIMATION`-th of the frame), the post-update I3 is captured into the comb pipeline.
- Comb pipeline: three registered stages, each y = x − x_prev (modulo 2^ACC_W).
  - Each stage advances one clk after the previous.
  - Delay registers update only on frame captures.
- Output conversion on comb result C, range 0..2^(3·R_LOG2):
  - S = C − 2^(3·R_LOG2−1), signed.
  - Clamp S to 2^(3·R_LOG2−1) − 1.
  - `pcm_out` = S >>> (3·R_LOG2 − WIDTH), arithmetic shift.
- Priming: the first 2 decimated outputs after reset are computed but not flagged. `pcm_out` updates for them; `pcm_valid` stays 0.
  - From the 3rd output on, every output strobes `pcm_valid`.
- `pdm_en` gaps stretch the frame in time without changing results.
- Reset (async assert, any time, including mid-frame or mid-comb) clears:
  - integrators, counter, comb delays, pipeline valids, priming count;
  - `pcm_out` = 0, `pcm_valid` = 0.
  - No partial output may be emitted after reset release.

## Timing

- Reset values: `pcm_out` = 0, `pcm_valid` = 0, all internal state 0.
- Latency: `pcm_valid` is high in the 3rd clk cycle after the cycle accepting the frame's final bit.
  - Final bit accepted in cycle t; `pcm_valid` high in cycle t+3.
  - `pcm_out` updates in the same cycle t+3 and holds until the next output.
- `pcm_valid` is exactly 1 cycle wide.
- Throughput with `pdm_en` tied high: one output per `DECIMATION` cycles. `DECIMATION` ≥ 8 guarantees the comb pipeline never holds two frames.
- A bit accepted in the same cycle as a frame capture belongs to the next frame.
- With `PDM_CIC_INPUT_SYNC_EN`, add 2 cycles to the latency (see Configuration).

## Configuration

- Macro: `PDM_CIC_INPUT_SYNC_EN`.
- Defined:
  - `pdm_in` and `pdm_en` each pass through a 2-flop synchronizer (reset to 0) before use.
  - Input-to-`pcm_valid` latency becomes t+5.
  - For asynchronous external PDM pins.
- Undefined:
  - Inputs are used directly; they must be synchronous to `clk` (e.g. an `SB_IO` registered input or internal loopback).
  - Latency t+3.

## Test plan

- All-ones, `pdm_en`=1:
  - first strobe at cycle 3·64+2 after reset release (macro off);
  - steady-state `pcm_out` = 0x7FFF (clamped).
- All-zeros, `pdm_en`=1 → steady-state `pcm_out` = 0x8000.
- Alternating 1,0,1,0…, `pdm_en`=1:
  - steady-state `pcm_out` = 0x0000;
  - strobes exactly 64 cycles apart, each 1 cycle wide.
- Same all-ones stream with `pdm_en` high every other cycle:
  - strobe spacing 128 cycles;
  - values identical to the `pdm_en`=1 case.
- Assert `reset_n` low for 1 cycle at mid-frame bit 37, and again one cycle after a frame capture:
  - `pcm_out` = 0 and `pcm_valid` = 0 immediately;
  - no strobe from the interrupted frame;
  - the next strobe is again the 3rd full frame after release.
- Loopback from `pdm_dac` (WIDTH 16) fed constant PCM 0x4000:
  - decoded `pcm_out` settles within ±0x0200 of 0x4000 after 8 outputs.
